// File: rtl/sram_io_bridge.sv
`default_nettype none
// ============================================================================
// sram_io_bridge : SLC-3 MAR/MDR requests to async 16-bit SRAM strobes, with
//                  one memory-mapped I/O word (switches in, hex display out).
// Optional byte lanes: define SRAM_BYTE_LANE_EN.          Revision 1.0
// ============================================================================
module sram_io_bridge #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [19:0] IO_ADDR     = 20'h0FFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [19:0] mem_addr,
  input  logic [15:0] mem_wdata,
`ifdef SRAM_BYTE_LANE_EN
  input  logic [1:0]  mem_be,
`endif
  output logic [15:0] mem_rdata,
  output logic        mem_ack,
  output logic        busy,
  input  logic [15:0] sw,
  output logic [15:0] hex_reg,
  output logic        CE,
  output logic        OE,
  output logic        WE,
  output logic        UB,
  output logic        LB,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_IO       = 3'd5,
    S_ACK      = 3'd6
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_we_q, req_we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] rdata_q, hex_q;
  logic        ack_q, busy_q;
  logic        drive_q, drive_d;
  logic        ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;
  logic        ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;
  logic [1:0]  be_in;
  logic        access;
  logic [15:0] lane_mask;

`ifdef SRAM_BYTE_LANE_EN
  assign be_in = mem_be;
`else
  assign be_in = 2'b11;
`endif

  assign lane_mask = {{8{be_q[1]}}, {8{be_q[0]}}};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_we_d = req_we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    addr_d   = addr_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          req_we_d = mem_we;
          wdata_d  = mem_wdata;
          be_d     = be_in;
          addr_d   = mem_addr;
          if (mem_addr == IO_ADDR) begin
            state_d = S_IO;
          end else if (mem_we) begin
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_RD;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) state_d = S_ACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = CNT_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = S_WR_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WR_HOLD: state_d = S_ACK;
      S_IO:      state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Pins are decoded from the upcoming state so they are registered, not
    // combinational from the request inputs.
    access  = (be_d != 2'b00);
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    drive_d = 1'b0;
    case (state_d)
      S_RD: begin
        ce_n_d = ~access;
        oe_n_d = ~access;
        ub_n_d = ~be_d[1];
        lb_n_d = ~be_d[0];
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_n_d  = ~access;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
        drive_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_d  = ~access;
        we_n_d  = ~access;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
        drive_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      req_we_q <= 1'b0;
      wdata_q  <= 16'h0000;
      be_q     <= 2'b11;
      addr_q   <= 20'h00000;
      rdata_q  <= 16'h0000;
      hex_q    <= 16'h0000;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      drive_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_we_q <= req_we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      ack_q    <= (state_d == S_ACK);
      busy_q   <= (state_d != S_IDLE);
      drive_q  <= drive_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      if (state_q == S_RD && cnt_q == 4'd0) begin
        rdata_q <= Data;
      end
      if (state_q == S_IO) begin
        if (req_we_q) hex_q   <= (hex_q & ~lane_mask) | (wdata_q & lane_mask);
        else          rdata_q <= sw;
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ack   = ack_q;
  assign busy      = busy_q;
  assign hex_reg   = hex_q;
  assign CE        = ce_n_q;
  assign OE        = oe_n_q;
  assign WE        = we_n_q;
  assign UB        = ub_n_q;
  assign LB        = lb_n_q;
  assign ADDR      = addr_q;
  assign Data      = drive_q ? wdata_q : 16'hzzzz;

endmodule
`default_nettype wire

// File: tb/tb_sram_io_bridge.sv
`default_nettype none
// ============================================================================
// tb_sram_io_bridge : vector table, hand-written corner sequences and random
//                     traffic against a transaction-level model. Revision 1.0
// ============================================================================
module tb_sram_io_bridge;
  localparam int          W   = 2;
  localparam logic [19:0] IOA = 20'h0FFFF;

  logic        Clk       = 1'b0;
  logic        Reset     = 1'b1;
  logic        mem_req   = 1'b0;
  logic        mem_we    = 1'b0;
  logic [19:0] mem_addr  = 20'h0;
  logic [15:0] mem_wdata = 16'h0;
  logic [15:0] sw        = 16'h0;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]  mem_be    = 2'b11;
`endif
  logic [15:0] mem_rdata, hex_reg;
  logic        mem_ack, busy, CE, OE, WE, UB, LB;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 Clk = ~Clk;

  sram_io_bridge #(.WAIT_CYCLES(W), .IO_ADDR(IOA)) dut (
    .Clk(Clk), .Reset(Reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef SRAM_BYTE_LANE_EN
    .mem_be(mem_be),
`endif
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .sw(sw),
    .hex_reg(hex_reg), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
    .ADDR(ADDR), .Data(Data)
  );

  // Small asynchronous SRAM: 0x00000-0x0003F and 0x10000-0x1003F.
  logic [15:0] sram [0:127];
  logic        sram_ready = 1'b0;
  logic        probe_en   = 1'b0;
  wire  [6:0]  sidx = {ADDR[16], ADDR[5:0]};
  assign Data = probe_en ? 16'h5A5A : (!CE && !OE && WE) ? sram[sidx] : 16'hzzzz;

  function automatic logic [15:0] init_pat(input logic [19:0] a);
    return 16'hC0DE ^ {7'd0, a[16], a[7:0]};
  endfunction

  always @(posedge Clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 128; i++) sram[i] <= init_pat({3'd0, i[6], 10'd0, i[5:0]});
      sram[7'h10] <= 16'h3A5C;
      sram_ready  <= 1'b1;
    end else if (!CE && !WE) begin
      if (!UB) sram[sidx][15:8] <= Data[15:8];
      if (!LB) sram[sidx][7:0]  <= Data[7:0];
    end
  end

  // Transaction-level reference model.
  logic [15:0] ref_mem [logic [19:0]];
  logic [15:0] ref_hex = 16'h0;

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_pat(a);
  endfunction

  task automatic model(input logic we, input logic [19:0] a, input logic [15:0] wd,
                       input logic [1:0] be, input logic [15:0] s,
                       output int lat, output logic [15:0] rd,
                       output int ce_c, output int oe_c, output int we_c);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    ce_c = 0; oe_c = 0; we_c = 0; rd = 16'h0;
    if (a == IOA) begin
      lat = 2;
      if (we) ref_hex = (ref_hex & ~m) | (wd & m);
      else    rd = s;
    end else if (we) begin
      lat = W + 3;
      if (be != 2'b00) begin ce_c = W + 2; we_c = W; end
      ref_mem[a] = (ref_rd(a) & ~m) | (wd & m);
    end else begin
      lat = W + 1; ce_c = W; oe_c = W;
      rd = ref_rd(a);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Call at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE cycle after ACK.
  task automatic do_txn(input logic we, input logic [19:0] a, input logic [15:0] wd,
                        input logic [1:0] be,
                        output int lat, output logic [15:0] rd,
                        output int ce_c, output int oe_c, output int we_c, output int bad);
    lat = 0; rd = 16'h0; ce_c = 0; oe_c = 0; we_c = 0; bad = 0;
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd;
`ifdef SRAM_BYTE_LANE_EN
    mem_be = be;
`endif
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge Clk); #1;
      if (n == 1) begin
        mem_req = 1'b0; mem_we = ~we; mem_addr = a ^ 20'h00005; mem_wdata = ~wd;
`ifdef SRAM_BYTE_LANE_EN
        mem_be = ~be;
`endif
      end
      if (!busy) bad++;
      if (!CE) begin
        ce_c++;
        if (ADDR !== a) bad++;
        if (UB !== ~be[1] || LB !== ~be[0]) bad++;
        if (we && Data !== wd) bad++;
      end else if (!UB || !LB || !OE || !WE) begin
        bad++;
      end
      if (!OE) oe_c++;
      if (!WE) we_c++;
      if (mem_ack) begin lat = n; rd = mem_rdata; end
    end
    @(posedge Clk); #1;
    if (mem_ack || busy) bad++;
  endtask

  task automatic run_and_check(input string tag, input logic we, input logic [19:0] a,
                               input logic [15:0] wd, input logic [1:0] be, input logic [15:0] s);
    int el, ece, eoe, ewe, lat, ce_c, oe_c, we_c, bad;
    logic [15:0] erd, rd;
    sw = s;
    model(we, a, wd, be, s, el, erd, ece, eoe, ewe);
    do_txn(we, a, wd, be, lat, rd, ce_c, oe_c, we_c, bad);
    check({tag, "_lat"}, lat, el);
    check({tag, "_ce_cycles"}, ce_c, ece);
    check({tag, "_oe_cycles"}, oe_c, eoe);
    check({tag, "_we_cycles"}, we_c, ewe);
    check({tag, "_protocol_errs"}, bad, 0);
    if (!we) check({tag, "_rdata"}, rd, erd);
    check({tag, "_hex"}, hex_reg, ref_hex);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_CE"}, CE, 1);
    check({tag, "_OE"}, OE, 1);
    check({tag, "_WE"}, WE, 1);
    check({tag, "_UB_LB"}, {UB, LB}, 2'b11);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ack"}, mem_ack, 0);
    check({tag, "_ADDR"}, ADDR, 0);
    check({tag, "_rdata"}, mem_rdata, 0);
    check({tag, "_hex"}, hex_reg, 0);
    probe_en = 1'b1; #1;
    check({tag, "_Data_released"}, Data, 16'h5A5A);
    probe_en = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    logic [15:0] exp_rd;
    logic [15:0] exp_hex;
    int          exp_lat;
    int          exp_ce;
    int          exp_oe;
    int          exp_we;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    int          lat, ce_c, oe_c, we_c, bad, el, ece, eoe, ewe, acks, prev, found, sel;
    logic [15:0] rd, erd;
    logic [19:0] run_addr, a;
    logic        in_run, we;
    logic [1:0]  be;

    tbl[0] = '{1'b1, 20'h00020, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, W+3, W+2, 0, W};
    tbl[1] = '{1'b0, 20'h00020, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, W+1, W, W, 0};
    tbl[2] = '{1'b0, 20'h00010, 16'h0000, 16'h0000, 16'h3A5C, 16'h0000, W+1, W, W, 0};
    tbl[3] = '{1'b1, 20'h0FFFF, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 2, 0, 0, 0};
    tbl[4] = '{1'b0, 20'h0FFFF, 16'h0000, 16'h0003, 16'h0003, 16'h1234, 2, 0, 0, 0};
    tbl[5] = '{1'b1, 20'h10000, 16'h5555, 16'h0000, 16'h0000, 16'h1234, W+3, W+2, 0, W};
    tbl[6] = '{1'b0, 20'h10000, 16'h0000, 16'h0000, 16'h5555, 16'h1234, W+1, W, W, 0};
    tbl[7] = '{1'b0, 20'h0001F, 16'h0000, 16'h0000, 16'hC0C1, 16'h1234, W+1, W, W, 0};
    ref_mem[20'h00010] = 16'h3A5C;

    #1 Reset = 1'b0;
    #4 check_reset_state("rst");
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 8; i++) begin
      sw = tbl[i].sw;
      model(tbl[i].we, tbl[i].addr, tbl[i].wdata, 2'b11, tbl[i].sw, el, erd, ece, eoe, ewe);
      do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 2'b11, lat, rd, ce_c, oe_c, we_c, bad);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      check($sformatf("vec%0d_ce_cycles", i), ce_c, tbl[i].exp_ce);
      check($sformatf("vec%0d_oe_cycles", i), oe_c, tbl[i].exp_oe);
      check($sformatf("vec%0d_we_cycles", i), we_c, tbl[i].exp_we);
      check($sformatf("vec%0d_protocol_errs", i), bad, 0);
      if (!tbl[i].we) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_hex", i), hex_reg, tbl[i].exp_hex);
    end

    // Asynchronous reset in the middle of the WE pulse.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 20'h0003F; mem_wdata = 16'h1111;
    found = 0;
    for (int n = 0; n < 10 && found == 0; n++) begin
      @(posedge Clk); #1;
      if (n == 0) mem_req = 1'b0;
      if (!WE) found = 1;
    end
    check("midwr_we_pulse_seen", found, 1);
    #2 Reset = 1'b0;
    #1 check_reset_state("midwr_rst");
    ref_hex = 16'h0;
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    run_and_check("postrst_rd", 1'b0, 20'h00020, 16'h0, 2'b11, 16'h0);

    // mem_req held high with mem_addr toggling every cycle.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h00020;
    acks = 0; prev = 0; bad = 0; in_run = 1'b0; run_addr = 20'h0;
    for (int n = 1; n <= 4 * (W + 2) - 1; n++) begin
      @(posedge Clk); #1;
      mem_addr = n[0] ? 20'h00010 : 20'h00020;
      if (!CE) begin
        if (!in_run) begin run_addr = ADDR; in_run = 1'b1; end
        else if (ADDR !== run_addr) bad++;
      end else begin
        in_run = 1'b0;
      end
      if (mem_ack) begin
        acks++;
        if ((acks == 1) ? (n != W + 1) : (n - prev != W + 2)) bad++;
        prev = n;
        if (mem_rdata !== ref_rd(run_addr)) bad++;
      end
    end
    mem_req = 1'b0;
    @(posedge Clk); #1;
    check("stream_ack_count", acks, 4);
    check("stream_errs", bad, 0);
    check("stream_idle_after", busy, 0);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2)      a = IOA;
      else if (sel < 6) a = 20'($urandom_range(0, 31));
      else              a = 20'h10000 | 20'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
`ifdef SRAM_BYTE_LANE_EN
      be = we ? 2'($urandom_range(1, 3)) : 2'b11;
`else
      be = 2'b11;
`endif
      run_and_check($sformatf("rand%0d", k), we, a, 16'($urandom), be, 16'($urandom));
    end

`ifdef SRAM_BYTE_LANE_EN
    run_and_check("be10_wr", 1'b1, 20'h00005, 16'hABCD, 2'b10, 16'h0);
    run_and_check("be10_rd", 1'b0, 20'h00005, 16'h0, 2'b11, 16'h0);
    check("be10_upper_only", mem_rdata, {8'hAB, init_pat(20'h00005) & 16'h00FF} & 16'hFFFF | 16'hAB00);
    run_and_check("be00_wr", 1'b1, 20'h00006, 16'h1234, 2'b00, 16'h0);
    run_and_check("be00_rd", 1'b0, 20'h00006, 16'h0, 2'b11, 16'h0);
    run_and_check("be01_io", 1'b1, IOA, 16'h77AA, 2'b01, 16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_io_bridge.md
Name: sram_io_bridge

Overview:
- Sits between the SLC-3 datapath (MAR/MDR memory requests) and the external asynchronous 16-bit SRAM pins (CE, UB, LB, OE, WE, ADDR, Data).
- Sequences multi-cycle read/write strobes with a programmable wait count.
- Decodes one memory-mapped I/O address: reads there return the switch bank; writes there load the hex-display register that feeds the HEX drivers.

Parameters:
- WAIT_CYCLES, 2, cycles OE (read) or WE (write) held active; legal range 1..15; 0 is illegal.
- IO_ADDR, 20'h0FFFF, address served by the I/O register instead of SRAM.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low reset
- mem_req  in  1  request strobe, sampled only in IDLE
- mem_we  in  1  1 = write, 0 = read; sampled with mem_req
- mem_addr  in  20  request address
- mem_wdata  in  16  write data (MDR)
- mem_rdata  out  16  read data, valid while mem_ack=1; held until the next read completes
- mem_ack  out  1  one-cycle completion pulse
- busy  out  1  high in every non-IDLE state
- sw  in  16  switch bank (S)
- hex_reg  out  16  I/O display register
- CE, OE, WE, UB, LB  out  1 each  SRAM controls, active-low
- ADDR  out  20  SRAM address
- Data  inout  16  SRAM data bus

Behaviour:
- Reset (async, Reset=0) forces immediately, even mid-transaction:
  - state IDLE; CE=OE=WE=UB=LB=1.
  - Data=Z; ADDR=0; mem_rdata=0; hex_reg=0; mem_ack=0; busy=0.
- All pin outputs are decoded from registered state and latched request registers. No combinational path from mem_* inputs to pins.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, IO, ACK.
- Edge E0 (IDLE, mem_req=1): latch addr, wdata, we into internal registers. Next state:
  - IO if addr==IO_ADDR;
  - else WR_SETUP if we=1;
  - else RD.
- Read:
  - RD lasts WAIT_CYCLES cycles with CE=OE=UB=LB=0 and ADDR=latched addr.
  - On the last RD edge, Data is captured into mem_rdata; go to ACK.
  - mem_ack is high in cycle E0+WAIT_CYCLES+1.
- Write:
  - WR_SETUP (1 cycle): CE=UB=LB=0, WE=1, Data driven.
  - WR_PULSE (WAIT_CYCLES cycles): WE=0.
  - WR_HOLD (1 cycle): WE=1, CE=0, Data still driven.
  - ACK follows; mem_ack is high in cycle E0+WAIT_CYCLES+3.
  - Data is driven only in the three WR states; Z everywhere else.
- IO (1 cycle):
  - No SRAM strobes.
  - Read: mem_rdata<=sw at the IO edge.
  - Write: hex_reg<=wdata at the IO edge.
  - ACK follows; mem_ack is high in cycle E0+2.
- ACK (1 cycle): all strobes inactive; mem_ack=1; return to IDLE. mem_req is ignored in ACK. The next request is accepted no earlier than the edge closing ACK+1 IDLE cycle.
- A mem_req held high across ack is treated as a new request once back in IDLE.
- Changes on mem_addr/mem_wdata/mem_we while busy have no effect (latched values are used).
- Wait counter:
  - 4-bit down-counter loaded with WAIT_CYCLES-1 on entry to RD/WR_PULSE.
  - Exit when it reaches 0.
  - It does not wrap.
- Addresses above IO_ADDR go to SRAM normally.

Optional Feature:
- Macro: SRAM_BYTE_LANE_EN.
- Defined:
  - Adds input mem_be[1:0], latched with the request.
  - UB=~be[1] and LB=~be[0] during active SRAM states.
  - be==2'b00 completes with the normal timing but keeps CE=1 (no SRAM access).
  - IO writes update only the enabled bytes of hex_reg.
- Undefined:
  - No mem_be port.
  - UB=LB=0 whenever CE=0; full-word IO writes.

Test Plan:
- Reset low mid-write (WE=0) -> same cycle: WE=CE=1, Data=Z, busy=0. After release, the first request behaves normally.
- Read addr 20'h00010, SRAM model returns 16'h3A5C, WAIT_CYCLES=2 -> OE low for exactly 2 cycles; mem_ack in cycle E0+3 with mem_rdata=16'h3A5C; single-cycle ack.
- Write 16'hBEEF to 20'h00020 -> WE low exactly 2 cycles, Data=16'hBEEF from WR_SETUP through WR_HOLD; ack at E0+5; readback returns 16'hBEEF.
- IO write 16'h1234 to 20'h0FFFF, then IO read with sw=16'h0003 -> hex_reg=16'h1234; no CE/OE/WE activity; mem_rdata=16'h0003; each ack at E0+2.
- mem_req held high continuously, alternating mem_addr -> one transaction per WAIT_CYCLES+2 read cycles; mem_addr changes while busy do not alter ADDR.
- SRAM_BYTE_LANE_EN defined, write with be=2'b10 -> UB=0, LB=1 during the write; be=2'b00 -> ack delivered with CE never asserted.
